// File: rtl/adc_seq.sv
// rtl/adc_seq.sv - sequential slice-serial adder/subtractor with NZVC flags
module adc_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Co,
   output logic             V,
   output logic             Z,
   output logic             N
);

   localparam int NSL = WIDTH / SLICE;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSL - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] sum;
   logic             cout;

   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NSL; i++) begin
         if (cnt == CW'(i)) begin
            a_sl = a_r[i*SLICE +: SLICE];
            b_sl = b_r[i*SLICE +: SLICE];
         end
      end
      {cout, sum} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
      // full result as it will stand once the top slice lands; only used on the last edge
      res = part;
      res[(NSL-1)*SLICE +: SLICE] = sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         part  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         S     <= '0;
         Co    <= 1'b0;
         V     <= 1'b0;
         Z     <= 1'b0;
         N     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r   <= A;
                  b_r   <= sub ? ~B : B;
                  carry <= sub ? ~C0 : C0;
                  cnt   <= '0;
                  part  <= '0;
                  busy  <= 1'b1;
                  state <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               for (int i = 0; i < NSL; i++) begin
                  if (cnt == CW'(i)) part[i*SLICE +: SLICE] <= sum;
               end
               carry <= cout;
               if (cnt == LAST) begin
                  S     <= res;
                  Co    <= cout;
                  V     <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res[WIDTH-1] != a_r[WIDTH-1]);
                  Z     <= (res == '0);
                  N     <= res[WIDTH-1];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_seq.sv
// tb/tb_adc_seq.sv - randomized self-checking bench for adc_seq (WIDTH 32, SLICE 8)
module tb_adc_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sub;
   logic [31:0] A;
   logic [31:0] B;
   logic        C0;
   logic        busy;
   logic        done;
   logic [31:0] S;
   logic        Co;
   logic        V;
   logic        Z;
   logic        N;

   int tests;
   int fails;

   adc_seq #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .C0(C0),
      .busy(busy), .done(done), .S(S), .Co(Co), .V(V), .Z(Z), .N(N)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // arithmetic reference: plain unsigned/signed math, no slicing
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic sb,
                        output logic [31:0] s, output logic co, output logic v,
                        output logic z, output logic n);
      longint sa, sbv, tru;
      logic [32:0] u;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (sb) begin
         s   = a - b - {31'd0, c0};
         co  = ({1'b0, a} >= ({1'b0, b} + {32'd0, c0}));
         tru = sa - sbv - longint'(c0);
      end else begin
         u   = {1'b0, a} + {1'b0, b} + {32'd0, c0};
         s   = u[31:0];
         co  = u[32];
         tru = sa + sbv + longint'(c0);
      end
      v = (tru > 64'sd2147483647) || (tru < -64'sd2147483648);
      z = (s == 32'd0);
      n = s[31];
   endtask

   // drive one operation, scramble ports while busy, wait (bounded) for done
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic sb,
                        output int lat, output logic [31:0] s, output logic co, output logic v,
                        output logic z, output logic n);
      @(negedge clk);
      A = a; B = b; C0 = c0; sub = sb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom; C0 = 1'($urandom); sub = 1'($urandom);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      s = S; co = Co; v = V; z = Z; n = N;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0; C0 = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, done, S, Co, V, Z, N} !== 38'd0) begin
         fails++;
         $display("FAIL reset_outputs: got busy=%b done=%b S=%h Co=%b V=%b Z=%b N=%b, want all 0",
                  busy, done, S, Co, V, Z, N);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] ta [6] = '{32'hFFFFFFFD, 32'h7FFFFFFF, 32'd3, 32'd5, 32'd3, 32'd0};
      logic [31:0] tb [6] = '{32'd5, 32'd1, 32'd4, 32'd5, 32'd4, 32'd0};
      logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        tsb[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] es [6] = '{32'd2, 32'h80000000, 32'd8, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [3:0]  ef [6] = '{4'b1000, 4'b0101, 4'b0000, 4'b1010, 4'b0001, 4'b0001}; // Co V Z N
      int lat;
      logic [31:0] s;
      logic co, v, z, n;
      for (int i = 0; i < 6; i++) begin
         do_op(ta[i], tb[i], tc[i], tsb[i], lat, s, co, v, z, n);
         tests++;
         if (lat !== 4) begin
            fails++;
            $display("FAIL directed_latency[%0d]: got %0d cycles, want 4", i, lat);
         end
         tests++;
         if (s !== es[i] || {co, v, z, n} !== ef[i]) begin
            fails++;
            $display("FAIL directed_result[%0d]: got S=%h CoVZN=%b, want S=%h CoVZN=%b",
                     i, s, {co, v, z, n}, es[i], ef[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] a, b, s, es;
      logic c0, sb, co, v, z, n, eco, ev, ez, en;
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom; c0 = 1'($urandom); sb = 1'($urandom);
         if (i % 8 == 0) b = (sb ? a : -a) - (sb ? {31'd0, c0} : -{31'd0, c0});
         model(a, b, c0, sb, es, eco, ev, ez, en);
         do_op(a, b, c0, sb, lat, s, co, v, z, n);
         tests++;
         if (lat !== 4 || s !== es || {co, v, z, n} !== {eco, ev, ez, en}) begin
            fails++;
            $display("FAIL random[%0d] a=%h b=%h c0=%b sub=%b: got lat=%0d S=%h CoVZN=%b, want lat=4 S=%h CoVZN=%b",
                     i, a, b, c0, sb, lat, s, {co, v, z, n}, es, {eco, ev, ez, en});
         end
         @(negedge clk);
         tests++;
         if (done !== 1'b0 || busy !== 1'b0 || S !== es) begin
            fails++;
            $display("FAIL random_hold[%0d]: got done=%b busy=%b S=%h, want done=0 busy=0 S=%h",
                     i, done, busy, S, es);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, a2, b, e1, e2;
      logic c0, sb, co, v, z, n;
      logic exp_done;
      a1 = $urandom; a2 = $urandom; b = $urandom; c0 = 1'($urandom); sb = 1'($urandom);
      model(a1, b, c0, sb, e1, co, v, z, n);
      model(a2, b, c0, sb, e2, co, v, z, n);
      @(negedge clk);
      A = a1; B = b; C0 = c0; sub = sb; start = 1'b1;
      for (int i = 0; i <= 14; i++) begin
         @(negedge clk);
         if (i == 1) A = a2;
         exp_done = (i % 5 == 4);
         tests++;
         if (done !== exp_done || busy !== !exp_done) begin
            fails++;
            $display("FAIL b2b_handshake[%0d]: got done=%b busy=%b, want done=%b busy=%b",
                     i, done, busy, exp_done, !exp_done);
         end
         if (exp_done) begin
            tests++;
            if (S !== ((i < 5) ? e1 : e2)) begin
               fails++;
               $display("FAIL b2b_result[%0d]: got S=%h, want %h", i, S, (i < 5) ? e1 : e2);
            end
         end
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      int lat, seen;
      logic [31:0] s;
      logic co, v, z, n;
      do_op(32'd1, 32'd1, 1'b0, 1'b0, lat, s, co, v, z, n);
      tests++;
      if (s !== 32'd2) begin
         fails++;
         $display("FAIL abort_pre: got S=%h, want 2", s);
      end
      @(negedge clk);
      A = 32'd563; B = 32'd23; C0 = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL abort_busy: got busy=%b, want 1", busy);
      end
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      tests++;
      if ({busy, done, S, Co, V, Z, N} !== 38'd0) begin
         fails++;
         $display("FAIL abort_outputs: got busy=%b done=%b S=%h Co=%b V=%b Z=%b N=%b, want all 0",
                  busy, done, S, Co, V, Z, N);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      tests++;
      if (seen !== 0) begin
         fails++;
         $display("FAIL abort_quiet: got %0d cycles with done/busy, want 0", seen);
      end
      do_op(32'd563, 32'd23, 1'b0, 1'b0, lat, s, co, v, z, n);
      tests++;
      if (lat !== 4 || s !== 32'd586 || {co, v, z, n} !== 4'b0000) begin
         fails++;
         $display("FAIL abort_restart: got lat=%0d S=%0d CoVZN=%b, want lat=4 S=586 CoVZN=0000",
                  lat, s, {co, v, z, n});
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
